truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, number of idle settle cycles per vector before sampling; legal range 0..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port expected  input  32  golden truth table; bit k = required F for vector k.
REQ-006 SHALL have port f_in  input  1  F output of the 5-input combinational stage under test.
REQ-007 SHALL have port vec  output  5  drive vector to the stage: vec[4]=A, vec[3]=B, vec[2]=C, vec[1]=D, vec[0]=E.
REQ-008 SHALL have port busy  output  1  high while a sweep or check is in progress.
REQ-009 SHALL have port done  output  1  high when the result outputs are valid.
REQ-010 SHALL have port pass  output  1  captured table equals expected.
REQ-011 SHALL have port table_out  output  32  captured truth table; bit k = f_in sampled while vec==k.
REQ-012 SHALL have port fail_valid  output  1  at least one mismatch found.
REQ-013 SHALL have port fail_index  output  5  lowest k with table_out[k] != expected[k]; 0 when fail_valid=0.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE, CHECK, DONE; all outputs registered.
REQ-015 IDLE/DONE: start=1 at an edge -> latch expected internally, clear table_out, done, pass, fail_valid, fail_index, set vec=0, busy=1, settle count=0, go SETTLE (or SAMPLE if SETTLE_CYCLES=0).
REQ-016 SETTLE: count increments each edge; after SETTLE_CYCLES edges go SAMPLE; vec held constant.
REQ-017 SAMPLE: one edge; write f_in into table_out[vec]; if vec==31 go CHECK, else vec<=vec+1, count<=0, go SETTLE (or stay SAMPLE if SETTLE_CYCLES=0).
REQ-018 Vector k SHALL be sampled at edge (k+1)*(SETTLE_CYCLES+1) counted from the start edge (edge 0).
REQ-019 CHECK: one edge; pass<=(table_out==latched expected); fail_valid<=!pass; fail_index<=priority-encoded lowest mismatching bit; busy<=0; done<=1; go DONE.
REQ-020 done SHALL first be high after edge 32*(SETTLE_CYCLES+1)+1 and stay high, results held, until next start or rst.
REQ-021 vec SHALL hold 31 in CHECK and DONE; no wrap to 0 until a new start.
REQ-022 start while busy=1 SHALL be ignored; sweep continues unaffected.
REQ-023 Changes on expected after the start edge SHALL not affect the result.
REQ-024 start and rst at same edge: rst wins.

Reset
REQ-025 rst=1 at any edge, including mid-sweep, SHALL force IDLE, vec=0, busy=0, done=0, pass=0, table_out=0, fail_valid=0, fail_index=0, settle count=0, latched expected=0.
REQ-026 After reset release, no sweep SHALL begin without a new start.

Verification
REQ-027 SETTLE_CYCLES=2, f_in tied to vec[0], expected=0xAAAAAAAA, start pulse -> vec steps 0..31 every 3 cycles, done rises after edge 97, table_out=0xAAAAAAAA, pass=1, fail_valid=0, fail_index=0.
REQ-028 Same stimulus, expected=0xAAAAAAAB -> pass=0, fail_valid=1, fail_index=0; expected=0x2AAAAAAA -> fail_index=31.
REQ-029 f_in = 5-input majority of vec, expected=0xFEE8E880 -> pass=1; flip expected bit 7 -> fail_index=7.
REQ-030 rst pulsed at edge 40 of a sweep -> all outputs 0 next cycle; subsequent start restarts at vec=0 and completes normally.
REQ-031 start re-pulsed at edge 10 of a sweep -> ignored, done still rises after edge 97; start pulsed while done=1 -> done clears, new sweep begins.
REQ-032 SETTLE_CYCLES=0 -> vec advances every cycle, done rises after edge 33, results as in REQ-027.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Steps a 5-bit vector through all 32 codes, samples the stage output F at each one,
// then compares the captured truth table with a golden table latched at start.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | holding vec while the stage under test settles
// SAMPLE | capturing f_in into table_out[vec]
// CHECK  | comparing captured table with latched expected
// DONE   | results valid and held until start or rst
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] expected,
  input  logic        f_in,
  output logic [4:0]  vec,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] table_out,
  output logic        fail_valid,
  output logic [4:0]  fail_index
);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam state_t POST_SAMPLE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [31:0] table_q, table_d;
  logic [31:0] exp_q, exp_d;
  logic        fv_q, fv_d;
  logic [4:0]  fi_q, fi_d;
  logic [31:0] diff;
  logic [4:0]  first_mis;

  // Lowest mismatching bit wins, so scan from the top down.
  always_comb begin
    diff      = table_q ^ exp_q;
    first_mis = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (diff[i]) first_mis = 5'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    table_d = table_q;
    exp_d   = exp_q;
    fv_d    = fv_q;
    fi_d    = fi_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          exp_d   = expected;
          table_d = 32'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fv_d    = 1'b0;
          fi_d    = 5'd0;
          vec_d   = 5'd0;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = POST_SAMPLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        table_d[vec_q] = f_in;
        if (vec_q == 5'd31) begin
          state_d = CHECK;
        end else begin
          vec_d   = vec_q + 5'd1;
          cnt_d   = 4'd0;
          state_d = POST_SAMPLE;
        end
      end
      CHECK: begin
        pass_d  = (diff == 32'd0);
        fv_d    = (diff != 32'd0);
        fi_d    = first_mis;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      vec_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      table_q <= 32'd0;
      exp_q   <= 32'd0;
      fv_q    <= 1'b0;
      fi_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      fv_q    <= fv_d;
      fi_q    <= fi_d;
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign table_out  = table_q;
  assign fail_valid = fv_q;
  assign fail_index = fi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: the stage under test is a lookup table indexed by vec; the
// expected result of each sweep is derived from that table and the golden word.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst, start, f_in;
  logic [31:0] exp_in, lut;
  logic [4:0]  vec, fail_index;
  logic        busy, done, pass, fail_valid;
  logic [31:0] table_out;

  logic        start0, f_in0, busy0, done0, pass0, fv0;
  logic [4:0]  vec0, fi0;
  logic [31:0] table0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic done_prev = 1'b0;

  typedef struct {
    logic [31:0] lut;
    logic [31:0] golden;
    int          due;
  } item_t;
  item_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign f_in  = lut[vec];
  assign f_in0 = vec0[0];

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(exp_in), .f_in(f_in),
    .vec(vec), .busy(busy), .done(done), .pass(pass), .table_out(table_out),
    .fail_valid(fail_valid), .fail_index(fail_index)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected(32'hAAAAAAAA), .f_in(f_in0),
    .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .table_out(table0),
    .fail_valid(fv0), .fail_index(fi0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] lowest_diff(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 32; k++) if (a[k] != b[k]) return 5'(k);
    return 5'd0;
  endfunction

  function automatic logic [31:0] lut_parity_e();
    logic [31:0] t;
    for (int k = 0; k < 32; k++) t[k] = (k % 2 == 1);
    return t;
  endfunction

  function automatic logic [31:0] lut_majority();
    logic [31:0] t;
    for (int k = 0; k < 32; k++) t[k] = ($countones(5'(k)) >= 3);
    return t;
  endfunction

  // Monitor: whenever done rises, the oldest outstanding sweep is retired.
  always @(negedge clk) begin
    if (!rst && done && !done_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        item_t e;
        e = sb.pop_front();
        chk("done_edge", 32'(cyc), 32'(e.due));
        chk("table_out", table_out, e.lut);
        chk("pass", 32'(pass), 32'(e.lut == e.golden));
        chk("fail_valid", 32'(fail_valid), 32'(e.lut != e.golden));
        chk("fail_index", 32'(fail_index), 32'(lowest_diff(e.lut, e.golden)));
        chk("vec_at_done", 32'(vec), 32'd31);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
    done_prev = done;
  end

  task automatic run_sweep(input logic [31:0] l, input logic [31:0] g,
                           input bit scramble, input bit stray);
    int t;
    @(negedge clk);
    lut    = l;
    exp_in = g;
    start  = 1'b1;
    sb.push_back('{lut: l, golden: g, due: cyc + 1 + 32 * 3 + 1});
    @(negedge clk);
    start = 1'b0;
    chk("start_clears_done", 32'(done), 32'd0);
    chk("start_sets_busy", 32'(busy), 32'd1);
    chk("start_vec", 32'(vec), 32'd0);
    if (scramble) exp_in = $urandom;
    if (stray) begin
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("sweep_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int t, m;
    logic [31:0] l, g;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; lut = 32'd0; exp_in = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_table", table_out, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_autostart", 32'(busy), 32'd0);

    run_sweep(lut_parity_e(), 32'hAAAAAAAA, 1'b0, 1'b0);
    run_sweep(lut_parity_e(), 32'hAAAAAAAB, 1'b0, 1'b0);
    run_sweep(lut_parity_e(), 32'h2AAAAAAA, 1'b0, 1'b0);
    run_sweep(lut_majority(), 32'hFEE8E880, 1'b0, 1'b0);
    run_sweep(lut_majority(), 32'hFEE8E800, 1'b0, 1'b0);
    run_sweep(lut_majority(), 32'hFEE8E880, 1'b1, 1'b1);

    // reset lands on edge 40 of a sweep
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_vec", 32'(vec), 32'd0);
    chk("midrst_table", table_out, 32'd0);
    chk("midrst_flags", {29'd0, done, pass, fail_valid}, 32'd0);
    chk("midrst_index", 32'(fail_index), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'd0);
    run_sweep(lut_parity_e(), 32'hAAAAAAAA, 1'b0, 1'b0);

    // reset and start together
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_beats_start_after", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      l = $urandom;
      case ($urandom_range(2))
        0: g = l;
        1: g = l ^ (32'd1 << $urandom_range(31));
        default: g = $urandom;
      endcase
      run_sweep(l, g, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // zero settle cycles: one vector per clock
    @(negedge clk);
    start0 = 1'b1;
    m = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    t = 0;
    while (!done0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("s0_done_edge", 32'(cyc), 32'(m + 33));
    chk("s0_table", table0, 32'hAAAAAAAA);
    chk("s0_pass", {30'd0, pass0, fv0}, 32'd2);
    chk("s0_index", 32'(fi0), 32'd0);
    chk("s0_vec", 32'(vec0), 32'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
